// File: rtl/axis_bram_player_pkg.sv
// ============================================================================
// Module  : axis_bram_player_pkg
// Brief   : Shared FSM encoding and read-pipeline constants for the player.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_bram_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned C_BRAM_RD_LATENCY = 1;

  // Skid depth needed to absorb every word still in flight when the sink stalls.
  localparam logic [2:0] C_CREDIT_LIMIT = 3'(C_BRAM_RD_LATENCY + 1);

endpackage

`default_nettype wire

// File: rtl/bram_read_skid.sv
// ============================================================================
// Module  : bram_read_skid
// Brief   : 2-entry register FIFO; output is taken straight from the head reg.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_read_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop = (r_count != 2'd0) && out_ready;

  // Upstream credit accounting guarantees no push ever lands on a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({in_valid, w_pop})
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) r_head <= in_data;
          else                 r_tail <= in_data;
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= in_data;
          end else begin
            r_head <= r_tail;
            r_tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = r_head;
  assign out_valid = (r_count != 2'd0);
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/axis_bram_player.sv
// ============================================================================
// Module  : axis_bram_player
// Brief   : Streams a preloaded BRAM table out on AXI4-Stream, one-shot or looped.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_bram_player
  import axis_bram_player_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH  = 10,
  parameter int CONTINUOUS       = 0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enable,
  input  logic [BRAM_ADDR_WIDTH:0]    cfg_length,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_addr,
  output logic                        sts_done,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata
);

  localparam int C_SKID_W = AXIS_TDATA_WIDTH + BRAM_ADDR_WIDTH + 1;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [BRAM_ADDR_WIDTH-1:0]  r_addr;
  logic [BRAM_ADDR_WIDTH-1:0]  r_last_addr;
  logic [BRAM_ADDR_WIDTH-1:0]  r_rd_addr;
  logic [BRAM_ADDR_WIDTH-1:0]  r_sts_addr;
  logic                        r_rd_valid;
  logic                        r_rd_last;
  logic                        r_pass_done;
  logic [BRAM_ADDR_WIDTH:0]    w_len_m1;
  logic                        w_is_last;
  logic                        w_issue;
  logic                        w_pop;
  logic                        w_empty;
  logic [1:0]                  w_count;
  logic [2:0]                  w_occupancy;
  logic [C_SKID_W-1:0]         w_skid_in;
  logic [C_SKID_W-1:0]         w_skid_out;
  logic                        w_skid_valid;

  assign w_pop       = w_skid_valid & m_axis_tready;
  // Occupancy net of the word leaving this cycle keeps the stream bubble-free.
  assign w_occupancy = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_rd_valid};
  assign w_is_last   = (r_addr == r_last_addr);
  assign w_issue     = (r_state == ST_RUN) && cfg_enable && (w_occupancy < C_CREDIT_LIMIT);
  assign w_empty     = (w_count == 2'd0) && !r_rd_valid;
  assign w_len_m1    = cfg_length - (BRAM_ADDR_WIDTH + 1)'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (cfg_enable && (cfg_length != '0)) w_state_next = ST_RUN;
      ST_RUN: begin
        if (!cfg_enable)                                      w_state_next = ST_DRAIN;
        else if (w_issue && w_is_last && (CONTINUOUS == 0))   w_state_next = ST_DRAIN;
      end
      ST_DRAIN: if (w_empty) w_state_next = r_pass_done ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!cfg_enable) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_rd_addr   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_pass_done <= 1'b0;
      r_sts_addr  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= w_issue;
      if ((r_state == ST_IDLE) && (w_state_next == ST_RUN)) begin
        r_addr      <= '0;
        r_last_addr <= w_len_m1[BRAM_ADDR_WIDTH-1:0];
        r_pass_done <= 1'b0;
      end
      // The BRAM samples r_addr on this edge; its data is pushed one edge later.
      if (w_issue) begin
        r_rd_addr <= r_addr;
        r_rd_last <= w_is_last;
        r_addr    <= (w_is_last && (CONTINUOUS != 0)) ? '0 : r_addr + BRAM_ADDR_WIDTH'(1);
        if (w_is_last && (CONTINUOUS == 0)) r_pass_done <= 1'b1;
      end
      if (w_pop) r_sts_addr <= w_skid_out[C_SKID_W-1 -: BRAM_ADDR_WIDTH];
    end
  end

  assign w_skid_in = {r_rd_addr, r_rd_last, bram_porta_rddata};

  bram_read_skid #(
    .WIDTH (C_SKID_W)
  ) u_skid (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_data   (w_skid_in),
    .in_valid  (r_rd_valid),
    .out_data  (w_skid_out),
    .out_valid (w_skid_valid),
    .out_ready (m_axis_tready),
    .count     (w_count)
  );

  assign m_axis_tdata    = w_skid_out[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tvalid   = w_skid_valid;
  assign m_axis_tlast    = w_skid_valid & w_skid_out[AXIS_TDATA_WIDTH];
  assign sts_addr        = r_sts_addr;
  assign sts_done        = (r_state == ST_DONE);
  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = ~aresetn;
  assign bram_porta_addr = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_axis_bram_player.sv
// ============================================================================
// Module  : tb_axis_bram_player
// Brief   : Directed self-checking bench for one-shot and continuous players.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_bram_player;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [10:0] len = '0;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic        tready0 = 1'b0, tready1 = 1'b0;
  logic [9:0]  sts_addr0, sts_addr1, addr0, addr1;
  logic        sts_done0, sts_done1;
  logic [31:0] tdata0, tdata1, rddata0, rddata1;
  logic        tvalid0, tvalid1, tlast0, tlast1;
  logic        bclk0, bclk1, brst0, brst1;

  logic [31:0] mem [0:1023];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q_data[$], q1_data[$];
  logic        q_last[$], q1_last[$];
  int          q_edge[$], q1_edge[$];
  logic        r_hold = 1'b0;
  logic [31:0] r_hold_data = '0;
  logic        r_hold_last = 1'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk) begin
    rddata0 <= mem[addr0];
    rddata1 <= mem[addr1];
  end

  axis_bram_player #(.AXIS_TDATA_WIDTH(32), .BRAM_ADDR_WIDTH(10), .CONTINUOUS(0)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_enable(en0), .cfg_length(len),
    .sts_addr(sts_addr0), .sts_done(sts_done0), .m_axis_tdata(tdata0),
    .m_axis_tvalid(tvalid0), .m_axis_tlast(tlast0), .m_axis_tready(tready0),
    .bram_porta_clk(bclk0), .bram_porta_rst(brst0), .bram_porta_addr(addr0),
    .bram_porta_rddata(rddata0)
  );

  axis_bram_player #(.AXIS_TDATA_WIDTH(32), .BRAM_ADDR_WIDTH(10), .CONTINUOUS(1)) u_dut_c (
    .aclk(aclk), .aresetn(aresetn), .cfg_enable(en1), .cfg_length(len),
    .sts_addr(sts_addr1), .sts_done(sts_done1), .m_axis_tdata(tdata1),
    .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1), .m_axis_tready(tready1),
    .bram_porta_clk(bclk1), .bram_porta_rst(brst1), .bram_porta_addr(addr1),
    .bram_porta_rddata(rddata1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Beat i of the one-shot capture; edge < 0 skips the timing comparison.
  task automatic expect_beat(input string tag, input int i, input logic [31:0] d,
                             input logic l, input int edge_no);
    check({tag, "_data"}, (i < q_data.size()) ? q_data[i] : 32'hxxxx_xxxx, d);
    check({tag, "_last"}, (i < q_last.size()) ? q_last[i] : 1'bx, l);
    if (edge_no >= 0)
      check({tag, "_edge"}, (i < q_edge.size()) ? q_edge[i] : -1, edge_no);
  endtask

  task automatic clear_q;
    q_data.delete(); q_last.delete(); q_edge.delete();
  endtask

  // Capture accepted beats and check tdata/tlast hold under backpressure.
  always @(negedge aclk) begin
    if (!aresetn) begin
      r_hold <= 1'b0;
    end else begin
      if (r_hold) begin
        check("hold_valid", tvalid0, 1'b1);
        check("hold_data", tdata0, r_hold_data);
        check("hold_last", tlast0, r_hold_last);
      end
      r_hold      <= tvalid0 && !tready0;
      r_hold_data <= tdata0;
      r_hold_last <= tlast0;
      if (tvalid0 && tready0) begin
        q_data.push_back(tdata0); q_last.push_back(tlast0); q_edge.push_back(cyc + 1);
      end
      if (tvalid1 && tready1) begin
        q1_data.push_back(tdata1); q1_last.push_back(tlast1); q1_edge.push_back(cyc + 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;

    // Reset state
    tick(2);
    check("rst_tvalid", tvalid0, 1'b0);
    check("rst_tlast", tlast0, 1'b0);
    check("rst_sts_addr", sts_addr0, 10'd0);
    check("rst_sts_done", sts_done0, 1'b0);
    check("rst_bram_addr", addr0, 10'd0);
    check("rst_bram_rst", brst0, 1'b1);
    aresetn = 1'b1;
    tick(2);
    check("bram_rst_rel", brst0, 1'b0);

    // One-shot N=4, tready=1: first accept three edges after enable is sampled
    clear_q();
    c0 = cyc;
    len = 11'd4; en0 = 1'b1; tready0 = 1'b1;
    for (int i = 0; i < 30 && !sts_done0; i++) tick();
    check("os4_done", sts_done0, 1'b1);
    check("os4_count", q_data.size(), 4);
    for (int i = 0; i < 4; i++)
      expect_beat("os4", i, 32'h100 + i, (i == 3), c0 + 4 + i);
    check("os4_sts_addr", sts_addr0, 10'd3);
    tick(5);
    check("os4_no_more", q_data.size(), 4);
    check("os4_tvalid_idle", tvalid0, 1'b0);
    check("os4_done_sticky", sts_done0, 1'b1);
    en0 = 1'b0;
    tick(2);
    check("os4_done_clr", sts_done0, 1'b0);

    // N=1: single beat with tlast
    clear_q();
    len = 11'd1; en0 = 1'b1;
    for (int i = 0; i < 20 && !sts_done0; i++) tick();
    check("n1_done", sts_done0, 1'b1);
    check("n1_count", q_data.size(), 1);
    expect_beat("n1", 0, 32'h100, 1'b1, -1);
    en0 = 1'b0;
    tick(2);

    // N=0: nothing happens
    clear_q();
    len = 11'd0; en0 = 1'b1;
    tick(10);
    check("n0_count", q_data.size(), 0);
    check("n0_tvalid", tvalid0, 1'b0);
    check("n0_done", sts_done0, 1'b0);
    en0 = 1'b0;
    tick(2);

    // N=16 with random backpressure
    clear_q();
    len = 11'd16; en0 = 1'b1;
    for (int i = 0; i < 400 && !sts_done0; i++) begin
      tready0 = 1'($urandom_range(0, 1));
      tick();
    end
    tready0 = 1'b1;
    check("rnd_done", sts_done0, 1'b1);
    check("rnd_count", q_data.size(), 16);
    for (int i = 0; i < 16; i++)
      expect_beat("rnd", i, 32'h100 + i, (i == 15), -1);
    check("rnd_sts_addr", sts_addr0, 10'd15);
    en0 = 1'b0;
    tick(2);

    // Enable dropped after 5 beats with the sink stalled
    clear_q();
    len = 11'd16; en0 = 1'b1; tready0 = 1'b1;
    for (int i = 0; i < 30 && q_data.size() < 5; i++) tick();
    tready0 = 1'b0;
    tick(4);
    en0 = 1'b0; tready0 = 1'b1;
    tick(12);
    check("drop_count", q_data.size(), 7);
    expect_beat("drop5", 5, 32'h105, 1'b0, -1);
    expect_beat("drop6", 6, 32'h106, 1'b0, -1);
    check("drop_done", sts_done0, 1'b0);
    check("drop_tvalid", tvalid0, 1'b0);
    check("drop_sts_addr", sts_addr0, 10'd6);

    // Asynchronous reset mid-pass with tvalid high
    clear_q();
    len = 11'd16; en0 = 1'b1; tready0 = 1'b0;
    tick(5);
    check("ar_tvalid_pre", tvalid0, 1'b1);
    #1 aresetn = 1'b0;
    #1;
    check("ar_tvalid_async", tvalid0, 1'b0);
    check("ar_bram_addr", addr0, 10'd0);
    check("ar_sts_addr", sts_addr0, 10'd0);
    en0 = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick();
    clear_q();
    en0 = 1'b1; tready0 = 1'b1;
    for (int i = 0; i < 20 && q_data.size() < 2; i++) tick();
    expect_beat("ar_restart0", 0, 32'h100, 1'b0, -1);
    expect_beat("ar_restart1", 1, 32'h101, 1'b0, -1);
    en0 = 1'b0;
    tick(10);

    // Continuous N=3: back-to-back wrap, tlast every third beat
    q1_data.delete(); q1_last.delete(); q1_edge.delete();
    c0 = cyc;
    len = 11'd3; en1 = 1'b1; tready1 = 1'b1;
    for (int i = 0; i < 40 && q1_data.size() < 9; i++) tick();
    check("cont_count", (q1_data.size() >= 9), 1'b1);
    for (int i = 0; i < 9; i++) begin
      check("cont_data", (i < q1_data.size()) ? q1_data[i] : 32'hxxxx_xxxx, 32'h100 + (i % 3));
      check("cont_last", (i < q1_last.size()) ? q1_last[i] : 1'bx, (i % 3) == 2);
      check("cont_edge", (i < q1_edge.size()) ? q1_edge[i] : -1, c0 + 4 + i);
    end
    check("cont_not_done", sts_done1, 1'b0);
    en1 = 1'b0;
    tick(10);
    check("cont_stop_tvalid", tvalid1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
